// File: rtl/scandoubler.sv
// Line-doubling scan converter: buffers one input line and replays it
// twice at double pixel rate with regenerated hsync/blanking.
module scandoubler #(
    parameter int ADDR_W = 10,
    parameter int IN_DIV = 4,
    parameter int HS_LEN = 64
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       pix_ce,
    input  logic       sol,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    input  logic       blank_n,
    input  logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_blank_n,
    output logic       vga_hsync_n,
    output logic       vga_vsync_n
);

    localparam int HALF  = IN_DIV / 2;
    localparam int DIV_W = $clog2(HALF);
    localparam int WORDS = 2 ** (ADDR_W + 1);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [ADDR_W:0]   HS_SLOTS = (ADDR_W + 1)'(HS_LEN);

    typedef enum logic [1:0] {
        IDLE,
        LINE0,
        LINE1
    } state_t;

    logic [12:0]       mem [WORDS];
    logic [12:0]       rd_word;

    logic              wr_bank;
    logic              rd_bank;
    logic              vs_line;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] len;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_ptr;

    state_t            state, state_n;
    logic [ADDR_W-1:0] slot, slot_n;
    logic [DIV_W-1:0]  div, div_n;
    logic              slot_end;
    logic              slot_last;

    logic              active;
    logic              in_sync;
    logic [ADDR_W:0]   rd_addr;

    logic              s1_act;
    logic              s1_sync;
    logic              s1_vs;

    // A pixel coinciding with sol already belongs to the new line.
    assign wr_sel = sol ? ~wr_bank : wr_bank;
    assign wr_ptr = sol ? '0 : wr_addr;

    always_ff @(posedge clk) begin
        if (pix_ce) begin
            mem[{wr_sel, wr_ptr}] <= {blank_n, red, green, blue};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_addr <= '0;
            len     <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            vs_line <= 1'b0;
        end else if (sol) begin
            len     <= wr_addr;
            wr_bank <= ~wr_bank;
            rd_bank <= wr_bank;
            vs_line <= vsync;
            wr_addr <= pix_ce ? ADDR_W'(1) : '0;
        end else if (pix_ce && wr_addr != ADDR_MAX) begin
            wr_addr <= wr_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            slot  <= '0;
            div   <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            div   <= div_n;
        end
    end

    assign slot_end  = (div == DIV_LAST);
    assign slot_last = (slot == len - ADDR_W'(1));

    always_comb begin
        state_n = state;
        slot_n  = slot;
        div_n   = div;
        if (sol) begin
            // The new len is the current wr_addr; an empty line never starts.
            state_n = (wr_addr == '0) ? IDLE : LINE0;
            slot_n  = '0;
            div_n   = '0;
        end else if (state != IDLE) begin
            div_n = slot_end ? '0 : div + DIV_W'(1);
            if (slot_end) begin
                if (slot_last) begin
                    slot_n  = '0;
                    state_n = (state == LINE0) ? LINE1 : IDLE;
                end else begin
                    slot_n = slot + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        active  = (state != IDLE);
        in_sync = ({1'b0, slot} < HS_SLOTS);
        rd_addr = {rd_bank, slot};
    end

    always_ff @(posedge clk) begin
        rd_word <= mem[rd_addr];
    end

    // Control travels alongside the RAM read to keep a fixed 2-clk latency.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_act  <= 1'b0;
            s1_sync <= 1'b0;
            s1_vs   <= 1'b0;
        end else begin
            s1_act  <= active;
            s1_sync <= in_sync;
            s1_vs   <= vs_line;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_blank_n <= 1'b0;
            vga_hsync_n <= 1'b1;
            vga_vsync_n <= 1'b1;
        end else begin
            vga_vsync_n <= ~s1_vs;
            if (s1_act) begin
                {vga_r, vga_g, vga_b} <= rd_word[11:0];
                vga_blank_n <= rd_word[12] & ~s1_sync;
                vga_hsync_n <= ~s1_sync;
            end else begin
                vga_r       <= '0;
                vga_g       <= '0;
                vga_b       <= '0;
                vga_blank_n <= 1'b0;
                vga_hsync_n <= 1'b1;
            end
        end
    end

endmodule

// File: doc/scandoubler.md
SCANDOUBLER -- requirements
Module: scandoubler

Interface
REQ-001 Parameter ADDR_W, default 10: line buffer address width; depth 2**ADDR_W pixels per bank.
REQ-002 Parameter IN_DIV, default 4: clk cycles per input pixel; even, >=4. Output pixel period is IN_DIV/2 clk.
REQ-003 Parameter HS_LEN, default 64: output hsync width in output pixel slots.
REQ-004 clk  in  1  56 MHz system clock, the same clock that drives the Denise core; all logic is on the rising edge.
REQ-005 arst_n  in  1  asynchronous active-low reset.
REQ-006 pix_ce  in  1  one-clk strobe per input pixel.
REQ-007 sol  in  1  start-of-line pulse from Denise, one clk wide.
REQ-008 red, green, blue  in  4 each  input pixel colour, sampled on pix_ce.
REQ-009 blank_n  in  1  input blanking, sampled with the colour.
REQ-010 vsync  in  1  input vertical sync, active high.
REQ-011 vga_r, vga_g, vga_b  out  4 each  doubled-rate colour.
REQ-012 vga_blank_n  out  1  output blanking.
REQ-013 vga_hsync_n  out  1  output horizontal sync, active low.
REQ-014 vga_vsync_n  out  1  output vertical sync, active low.

Function
REQ-015 Two line banks of 13-bit words {blank_n, red, green, blue} SHALL be used in ping-pong: one bank is written while the other is read.
REQ-016 On pix_ce, the sampled word SHALL be written to wr_bank[wr_addr], and then wr_addr SHALL increment.
REQ-017 wr_addr SHALL saturate at 2**ADDR_W-1: further pixels overwrite the last location and the address does not wrap.
REQ-018 On sol, the block SHALL latch len = wr_addr, toggle wr_bank, set rd_bank to the previous wr_bank, clear wr_addr to 0, and latch vsync into vs_line.
REQ-019 If sol and pix_ce coincide, the pixel SHALL be written at address 0 of the new bank.
REQ-020 Read FSM states: IDLE, LINE0, LINE1. On sol, any state SHALL go to LINE0 with slot=0 and the divider cleared.
REQ-021 In LINE0 and LINE1, slot SHALL advance every IN_DIV/2 clk.
REQ-022 At slot==len-1 end: LINE0 SHALL go to LINE1 with slot=0, and LINE1 SHALL go to IDLE.
REQ-023 If len==0, the FSM SHALL stay in IDLE.
REQ-024 A sol arriving before LINE1 completes SHALL abort the line and restart LINE0; no error is flagged.
REQ-025 Each slot SHALL read rd_bank[slot] through a synchronous RAM read.
REQ-026 Output registers SHALL update exactly 2 clk after the slot begins; this is the fixed pipeline latency.
REQ-027 In LINE0 and LINE1, vga_r/g/b and vga_blank_n SHALL equal the stored word, except that vga_blank_n is forced to 0 while slot<HS_LEN.
REQ-028 vga_hsync_n SHALL be 0 for slots 0..HS_LEN-1 of each output line and 1 otherwise. It follows the same 2-clk latency as the pixel data.
REQ-029 If len<=HS_LEN, the whole output line SHALL be sync and blank.
REQ-030 In IDLE, after the 2-clk pipeline drains: vga_r/g/b=0, vga_blank_n=0, vga_hsync_n=1.
REQ-031 vga_vsync_n SHALL equal ~vs_line, updating with the same 2-clk latency as pixel data. It is therefore delayed by one input line so that it aligns with the buffered data.
REQ-032 The second output line SHALL be a bit-exact repeat of the first.

Reset
REQ-033 While arst_n=0: wr_addr=0, len=0, wr_bank=0, rd_bank=1, vs_line=0, FSM=IDLE, slot=0, divider=0.
REQ-034 While arst_n=0: vga_r/g/b=0, vga_blank_n=0, vga_hsync_n=1, vga_vsync_n=1.
REQ-035 Reset asserted mid-line SHALL force all of the above immediately. After release, no output line starts until the second sol, because the first sol latches len from an empty line.
REQ-036 Line buffer contents are not reset, and are never visible before being written.

Verification
REQ-037 Reset release; one sol; then 200 pixels with value 0xABC and blank_n=1; then sol -> LINE0 then LINE1, each 200 slots of 2 clk. Slots 0..63 show hsync_n=0 and blank_n=0; slots 64..199 show rgb=0xABC and blank_n=1; then IDLE.
REQ-038 Ramp: pixel i has rgb=i for 300 pixels, followed by sol -> vga output slot s shows s for s>=64 in both lines, 2 clk after the slot start.
REQ-039 Feed 1100 pixels in one line -> len=1023; location 1023 holds the last pixel; no wrap into address 0.
REQ-040 sol with pix_ce in the same clk -> that pixel appears at slot 0 of the following line's readout.
REQ-041 vsync=1 at a sol -> vga_vsync_n=0 throughout the next two output lines. An early sol during LINE1 -> LINE0 restarts at slot 0 with no glitch on hsync_n.
REQ-042 arst_n pulsed low during LINE0 -> outputs reach reset values within the same cycle. After release, the first sol produces no output and the second sol produces output.
